// File: rtl/snitch_perf_cnt_unit_pkg.sv
// Shared definitions for the cluster performance-counter unit.
//   core_events_t : per-core event strobe bundle; its width sets the default
//                   number of events per core.
//   PerfCtrlOffset / PerfCntOffset : byte offsets inside the counter window.
//   Ctrl*Bit : bit positions inside the CTRL register.
package snitch_perf_cnt_unit_pkg;

  typedef struct packed {
    logic retired_instr;
    logic retired_load;
    logic retired_i;
    logic retired_acc;
  } core_events_t;

  localparam int unsigned PerfCtrlOffset = 32'h000;
  localparam int unsigned PerfCntOffset  = 32'h100;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlClrBit   = 1;
  localparam int unsigned CtrlSatBit   = 2;
  localparam int unsigned CtrlIrqEnBit = 3;

  // CTRL read-back word; CLR is write-only and always reads 0.
  function automatic logic [31:0] ctrl_word(input logic en, input logic sat,
                                            input logic irq_en);
    logic [31:0] w;
    w = '0;
    w[CtrlEnBit]    = en;
    w[CtrlSatBit]   = sat;
    w[CtrlIrqEnBit] = irq_en;
    return w;
  endfunction

endpackage

// File: rtl/snitch_perf_cnt_unit_counter.sv
// Single performance counter with sticky overflow flag.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   inc_i          : count one event this cycle
//   clr_i          : zero counter and overflow flag (highest priority)
//   load_lo_i      : load cnt[31:0] from wdata_i
//   load_hi_i      : load cnt[CntWidth-1:32] from wdata_i, clear overflow
//   sat_i          : 1 = saturate at all-ones, 0 = wrap to zero
//   wdata_i        : register write data
//   cnt_o, ovf_o   : current counter value and sticky overflow flag
module snitch_perf_counter #(
  parameter int unsigned CntWidth = 48
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                clr_i,
  input  logic                load_lo_i,
  input  logic                load_hi_i,
  input  logic                sat_i,
  input  logic [31:0]         wdata_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                ovf_o
);

  logic [CntWidth-1:0] cnt_d, cnt_q;
  logic                ovf_d, ovf_q;
  logic                all_ones;

  assign all_ones = &cnt_q;

  // clear > register write > increment
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (load_hi_i) begin
      cnt_d[CntWidth-1:32] = wdata_i[CntWidth-33:0];
      ovf_d                = 1'b0;
    end else if (inc_i) begin
      if (all_ones) begin
        ovf_d = 1'b1;
        if (!sat_i) cnt_d = '0;
      end else begin
        cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/snitch_perf_cnt_unit.sv
// Cluster performance-counter unit: NrCores*NrEvents counters behind a
// 32-bit register window with registered single-beat responses.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   events_i            : event strobes, index = core*NrEvents + event
//   req_valid_i/ready_o : request handshake
//   req_addr_i          : byte offset into the window
//   req_write_i         : 1 = write, 0 = read
//   req_wdata_i         : write data
//   resp_valid_o/ready_i: response handshake
//   resp_rdata_o        : read data (0 on writes and errors)
//   resp_error_o        : misaligned or unmapped access
//   ovf_irq_o           : level interrupt, any overflow while IRQ_EN
module snitch_perf_cnt_unit
  import snitch_perf_cnt_unit_pkg::*;
#(
  parameter int unsigned NrCores   = 8,
  parameter int unsigned NrEvents  = $bits(core_events_t),
  parameter int unsigned CntWidth  = 48,
  parameter int unsigned AddrWidth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NrCores*NrEvents-1:0]  events_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic                         req_write_i,
  input  logic [31:0]                  req_wdata_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [31:0]                  resp_rdata_o,
  output logic                         resp_error_o,
  output logic                         ovf_irq_o
);

  localparam int unsigned NumCnt = NrCores * NrEvents;
  localparam int unsigned IdxW   = (NumCnt > 1) ? $clog2(NumCnt) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        en_d, en_q;
  logic        sat_d, sat_q;
  logic        irq_en_d, irq_en_q;
  logic [31:0] shadow_d, shadow_q;
  logic        resp_valid_q;
  logic [31:0] rdata_d, rdata_q;
  logic        err_d, err_q;
  logic        irq_q;

  logic [NumCnt-1:0][CntWidth-1:0] cnt;
  logic [NumCnt-1:0]               ovf;
  logic [NumCnt-1:0]               inc, load_lo, load_hi;

  // ---------------------------------------------------------------------------
  // Handshake and decode
  // ---------------------------------------------------------------------------
  logic                 acc;
  logic                 aligned, is_ctrl, is_cnt, is_hi, dec_err;
  logic [AddrWidth-1:0] cnt_off, cnt_idx;
  logic [IdxW-1:0]      sel;
  logic                 clr;

  assign req_ready_o = !resp_valid_q | resp_ready_i;
  assign acc         = req_valid_i & req_ready_o;

  assign cnt_off = req_addr_i - AddrWidth'(PerfCntOffset);
  assign cnt_idx = cnt_off >> 3;
  assign sel     = cnt_idx[IdxW-1:0];
  assign is_hi   = cnt_off[2];
  assign aligned = (req_addr_i[1:0] == 2'b00);
  assign is_ctrl = (req_addr_i == AddrWidth'(PerfCtrlOffset));
  // Lower bound keeps addresses below the counter block from aliasing via
  // the subtraction wrap-around.
  assign is_cnt  = (req_addr_i >= AddrWidth'(PerfCntOffset)) &&
                   (cnt_idx < AddrWidth'(NumCnt));
  assign dec_err = !aligned || !(is_ctrl || is_cnt);

  assign clr = acc & req_write_i & is_ctrl & req_wdata_i[CtrlClrBit];

  // ---------------------------------------------------------------------------
  // Counter array
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < NumCnt; j++) begin : g_cnt
    assign inc[j]     = en_q & events_i[j];
    assign load_lo[j] = acc & req_write_i & !dec_err & is_cnt & !is_hi &
                        (sel == IdxW'(j));
    assign load_hi[j] = acc & req_write_i & !dec_err & is_cnt & is_hi &
                        (sel == IdxW'(j));

    snitch_perf_counter #(
      .CntWidth (CntWidth)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (inc[j]),
      .clr_i     (clr),
      .load_lo_i (load_lo[j]),
      .load_hi_i (load_hi[j]),
      .sat_i     (sat_q),
      .wdata_i   (req_wdata_i),
      .cnt_o     (cnt[j]),
      .ovf_o     (ovf[j])
    );
  end

  // High word of the addressed counter as it would appear on the bus; this
  // is what a low-word read snapshots into the shadow.
  logic [CntWidth-1:0] sel_cnt;
  logic                sel_ovf;
  logic [31:0]         hi_live;

  assign sel_cnt = cnt[sel];
  assign sel_ovf = ovf[sel];

  always_comb begin
    hi_live                 = '0;
    hi_live[CntWidth-33:0]  = sel_cnt[CntWidth-1:32];
    hi_live[31]             = sel_ovf;
  end

  // ---------------------------------------------------------------------------
  // Register access
  // ---------------------------------------------------------------------------
  always_comb begin
    en_d     = en_q;
    sat_d    = sat_q;
    irq_en_d = irq_en_q;
    shadow_d = shadow_q;
    rdata_d  = '0;
    err_d    = 1'b0;

    if (clr) shadow_d = '0;

    if (acc) begin
      if (dec_err) begin
        err_d = 1'b1;
      end else if (req_write_i) begin
        if (is_ctrl) begin
          en_d     = req_wdata_i[CtrlEnBit];
          sat_d    = req_wdata_i[CtrlSatBit];
          irq_en_d = req_wdata_i[CtrlIrqEnBit];
        end
      end else if (is_ctrl) begin
        rdata_d = ctrl_word(en_q, sat_q, irq_en_q);
      end else if (is_hi) begin
        rdata_d = shadow_q;
      end else begin
        // Low word and shadow both come from the pre-increment value, so a
        // lo/hi read pair forms one consistent snapshot.
        rdata_d  = sel_cnt[31:0];
        shadow_d = hi_live;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q         <= 1'b0;
      sat_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      shadow_q     <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      en_q     <= en_d;
      sat_q    <= sat_d;
      irq_en_q <= irq_en_d;
      shadow_q <= shadow_d;
      irq_q    <= irq_en_q & (|ovf);
      if (acc) begin
        resp_valid_q <= 1'b1;
        rdata_q      <= rdata_d;
        err_q        <= err_d;
      end else if (resp_ready_i) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_error_o = err_q;
  assign ovf_irq_o    = irq_q;

endmodule
